// File: rtl/pwl_buf_pkg.sv
// Shared types and sizing for the PWL batch buffer.
// SAMPLE_WIDTH and BATCH_WIDTH are fixed here so every file agrees on batch_t.
package pwl_buf_pkg;

  localparam int SAMPLE_WIDTH  = 16;
  localparam int BATCH_WIDTH   = 256;
  localparam int BATCH_SAMPLES = BATCH_WIDTH / SAMPLE_WIDTH;

  typedef logic [BATCH_SAMPLES-1:0][SAMPLE_WIDTH-1:0] batch_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_e;

endpackage

// File: rtl/pwl_batch_buffer_fifo.sv
// batch_fifo_sync: synchronous FIFO of batch_t with first-word-fall-through
// read data, occupancy count, full flag and a one-cycle flush.
module batch_fifo_sync
  import pwl_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  batch_t           wr_data,
  input  logic             rd_en,
  output batch_t           rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  batch_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when a read frees an entry the same cycle.
  always_comb begin
    rd_fire  = rd_en && (count_q != '0) && !flush;
    wr_fire  = wr_en && !flush && (!full || rd_fire);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pwl_batch_buffer.sv
// Elastic batch buffer between pwl_generator and the DAC0 stream: primes, streams,
// counts underflows. Optional PWL_BUF_IDLE_HOLD_EN repeats the last sample when empty.
//
// state  | meaning
// IDLE   | not streaming; FIFO accepts writes
// PRIME  | waiting for registered count >= PRIME_LEVEL
// STREAM | presenting batches to the DAC on valid/ready
// FLUSH  | one cycle: pointers and count cleared, writes ignored
module pwl_batch_buffer
  import pwl_buf_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int RDY_MARGIN      = 2,
  parameter int PRIME_LEVEL     = 4,
  parameter int UFLOW_CNT_WIDTH = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [BATCH_SAMPLES-1:0][SAMPLE_WIDTH-1:0] batch_in,
  input  logic                                     valid_batch_in,
  output logic                                     dac0_rdy,
  input  logic                                     run,
  input  logic                                     halt,
  output logic [BATCH_SAMPLES-1:0][SAMPLE_WIDTH-1:0] batch_out,
  output logic                                     valid_out,
  input  logic                                     ready_in,
  output logic                                     active,
  output logic                                     overflow,
  output logic [UFLOW_CNT_WIDTH-1:0]               underflow_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                     state_q, state_d;
  logic                       overflow_q, overflow_d;
  logic [UFLOW_CNT_WIDTH-1:0] uflow_q, uflow_d;
  logic                       flush;
  logic                       rd_en;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic [CNT_W-1:0]           fifo_count;
  batch_t                     fifo_data;
`ifdef PWL_BUF_IDLE_HOLD_EN
  logic [SAMPLE_WIDTH-1:0]    last_q, last_d;
`endif

  batch_fifo_sync #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (valid_batch_in),
    .wr_data (batch_in),
    .rd_en   (rd_en),
    .rd_data (fifo_data),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  assign fifo_empty    = (fifo_count == '0);
  assign dac0_rdy      = (fifo_count < CNT_W'(FIFO_DEPTH - RDY_MARGIN));
  assign overflow      = overflow_q;
  assign underflow_cnt = uflow_q;

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    uflow_d    = uflow_q;
    flush      = 1'b0;
    valid_out  = 1'b0;
    active     = 1'b0;
    batch_out  = '0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = FLUSH;
        end else if (run) begin
          state_d    = PRIME;
          overflow_d = 1'b0;
        end
      end
      PRIME: begin
        active = 1'b1;
        if (halt) state_d = FLUSH;
        else if (fifo_count >= CNT_W'(PRIME_LEVEL)) state_d = STREAM;
      end
      STREAM: begin
        active = 1'b1;
        if (!fifo_empty) begin
          valid_out = 1'b1;
          batch_out = fifo_data;
        end else begin
`ifdef PWL_BUF_IDLE_HOLD_EN
          valid_out = 1'b1;
          batch_out = {BATCH_SAMPLES{last_q}};
`endif
          if (ready_in && (uflow_q != {UFLOW_CNT_WIDTH{1'b1}})) uflow_d = uflow_q + 1'b1;
        end
        if (halt) state_d = FLUSH;
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Hold batches never pop the FIFO.
    rd_en = valid_out && ready_in && !fifo_empty;

    // A drop in the same cycle as run still reports, so set wins over clear.
    if (valid_batch_in && !flush && fifo_full && !rd_en) overflow_d = 1'b1;
  end

`ifdef PWL_BUF_IDLE_HOLD_EN
  always_comb begin
    last_d = last_q;
    if (flush) last_d = '0;
    else if (rd_en) last_d = fifo_data[BATCH_SAMPLES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= '0;
    else     last_q <= last_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      uflow_q    <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      uflow_q    <= uflow_d;
    end
  end

endmodule

// File: tb/tb_pwl_batch_buffer.sv
// Directed bench for pwl_batch_buffer: priming, ordering, overflow, underflow,
// full read/write, flush and mid-stream reset. Honours PWL_BUF_IDLE_HOLD_EN.
module tb_pwl_batch_buffer;
  import pwl_buf_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  batch_t batch_in;
  logic   valid_batch_in;
  logic   dac0_rdy;
  logic   run;
  logic   halt;
  batch_t batch_out;
  logic   valid_out;
  logic   ready_in;
  logic   active;
  logic   overflow;
  logic [15:0] underflow_cnt;

  int tests_run = 0;
  int fails     = 0;

  pwl_batch_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .batch_in       (batch_in),
    .valid_batch_in (valid_batch_in),
    .dac0_rdy       (dac0_rdy),
    .run            (run),
    .halt           (halt),
    .batch_out      (batch_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .active         (active),
    .overflow       (overflow),
    .underflow_cnt  (underflow_cnt)
  );

  always #5 clk = ~clk;

  function automatic batch_t mk(input int k);
    batch_t b;
    for (int i = 0; i < BATCH_SAMPLES; i++) b[i] = 16'(k);
    return b;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

`ifdef PWL_BUF_IDLE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  task automatic test_reset;
    rst = 1'b1; valid_batch_in = 1'b0; batch_in = '0; run = 1'b0; halt = 1'b0; ready_in = 1'b0;
    step; step;
    rst = 1'b0;
    step;
    tests_run++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    tests_run++; if (dac0_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy got %b exp 1", dac0_rdy); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    tests_run++; if (underflow_cnt !== 16'd0) begin fails++; $display("FAIL reset_uflow got %0d exp 0", underflow_cnt); end
    tests_run++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active got %b exp 0", active); end
    tests_run++; if (batch_out !== '0) begin fails++; $display("FAIL reset_batch got %h exp 0", batch_out); end
  endtask

  task automatic test_prime_stream;
    for (int k = 1; k <= 6; k++) begin
      valid_batch_in = 1'b1; batch_in = mk(k);
      step;
      if (k == 5) begin tests_run++; if (dac0_rdy !== 1'b1) begin fails++; $display("FAIL rdy_at5 got %b exp 1", dac0_rdy); end end
      if (k == 6) begin tests_run++; if (dac0_rdy !== 1'b0) begin fails++; $display("FAIL rdy_at6 got %b exp 0", dac0_rdy); end end
    end
    valid_batch_in = 1'b0; run = 1'b1; ready_in = 1'b1;
    step;
    run = 1'b0;
    tests_run++; if (active !== 1'b1 || valid_out !== 1'b0) begin fails++; $display("FAIL prime_state got active=%b valid=%b exp 1/0", active, valid_out); end
    step;
    for (int k = 1; k <= 6; k++) begin
      tests_run++; if (valid_out !== 1'b1 || batch_out !== mk(k)) begin fails++; $display("FAIL stream_order k=%0d got valid=%b data=%h", k, valid_out, batch_out[0]); end
      if (k == 2) begin tests_run++; if (dac0_rdy !== 1'b1) begin fails++; $display("FAIL rdy_rise got %b exp 1", dac0_rdy); end end
      step;
    end
    ready_in = 1'b0;
  endtask

  task automatic test_underflow;
    ready_in = 1'b1;
    tests_run++; if (valid_out !== HOLD) begin fails++; $display("FAIL empty_valid got %b exp %b", valid_out, HOLD); end
    tests_run++; if (batch_out !== (HOLD ? mk(6) : batch_t'('0))) begin fails++; $display("FAIL empty_batch got %h", batch_out); end
    step; step; step;
    ready_in = 1'b0;
    tests_run++; if (underflow_cnt !== 16'd3) begin fails++; $display("FAIL uflow3 got %0d exp 3", underflow_cnt); end
    halt = 1'b1;
    step;
    halt = 1'b0;
    step;
  endtask

  task automatic test_overflow;
    for (int k = 11; k <= 19; k++) begin
      valid_batch_in = 1'b1; batch_in = mk(k);
      step;
    end
    valid_batch_in = 1'b0;
    tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", overflow); end
    tests_run++; if (dac0_rdy !== 1'b0) begin fails++; $display("FAIL ovf_rdy got %b exp 0", dac0_rdy); end
    run = 1'b1;
    step;
    run = 1'b0;
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    step;
    ready_in = 1'b1;
    for (int k = 11; k <= 18; k++) begin
      tests_run++; if (valid_out !== 1'b1 || batch_out !== mk(k)) begin fails++; $display("FAIL ovf_order k=%0d got valid=%b data=%h", k, valid_out, batch_out[0]); end
      step;
    end
    ready_in = 1'b0;
    tests_run++; if (valid_out !== HOLD || batch_out !== (HOLD ? mk(18) : batch_t'('0))) begin fails++; $display("FAIL ovf_drained got valid=%b data=%h", valid_out, batch_out[0]); end
    tests_run++; if (underflow_cnt !== 16'd3) begin fails++; $display("FAIL uflow_kept got %0d exp 3", underflow_cnt); end
  endtask

  task automatic test_back_to_back;
    for (int k = 21; k <= 28; k++) begin
      valid_batch_in = 1'b1; batch_in = mk(k);
      step;
    end
    batch_in = mk(29); ready_in = 1'b1;
    tests_run++; if (valid_out !== 1'b1 || batch_out !== mk(21)) begin fails++; $display("FAIL full_head got valid=%b data=%h exp 21", valid_out, batch_out[0]); end
    step;
    valid_batch_in = 1'b0;
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_rw_ovf got %b exp 0", overflow); end
    tests_run++; if (dac0_rdy !== 1'b0) begin fails++; $display("FAIL full_rw_rdy got %b exp 0", dac0_rdy); end
    for (int k = 22; k <= 29; k++) begin
      tests_run++; if (valid_out !== 1'b1 || batch_out !== mk(k)) begin fails++; $display("FAIL full_order k=%0d got valid=%b data=%h", k, valid_out, batch_out[0]); end
      step;
    end
    ready_in = 1'b0;
  endtask

  task automatic test_halt_flush;
    for (int k = 31; k <= 35; k++) begin
      valid_batch_in = 1'b1; batch_in = mk(k);
      step;
    end
    valid_batch_in = 1'b0; halt = 1'b1;
    step;
    halt = 1'b0; valid_batch_in = 1'b1; batch_in = mk(99);
    tests_run++; if (active !== 1'b0 || valid_out !== 1'b0) begin fails++; $display("FAIL flush_cycle got active=%b valid=%b exp 0/0", active, valid_out); end
    step;
    valid_batch_in = 1'b0;
    tests_run++; if (active !== 1'b0 || valid_out !== 1'b0 || dac0_rdy !== 1'b1) begin fails++; $display("FAIL idle_after_flush got active=%b valid=%b rdy=%b", active, valid_out, dac0_rdy); end
    run = 1'b1;
    step;
    run = 1'b0;
    step;
    tests_run++; if (active !== 1'b1 || valid_out !== 1'b0) begin fails++; $display("FAIL prime_empty got active=%b valid=%b exp 1/0", active, valid_out); end
    for (int k = 41; k <= 44; k++) begin
      valid_batch_in = 1'b1; batch_in = mk(k);
      step;
    end
    valid_batch_in = 1'b0;
    step;
    tests_run++; if (valid_out !== 1'b1 || batch_out !== mk(41)) begin fails++; $display("FAIL flush_discard got valid=%b data=%h exp 41", valid_out, batch_out[0]); end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    step;
    tests_run++; if (valid_out !== 1'b0 || active !== 1'b0 || dac0_rdy !== 1'b1) begin fails++; $display("FAIL rst_mid got valid=%b active=%b rdy=%b", valid_out, active, dac0_rdy); end
    tests_run++; if (underflow_cnt !== 16'd0) begin fails++; $display("FAIL rst_mid_uflow got %0d exp 0", underflow_cnt); end
    rst = 1'b0;
    step;
  endtask

  initial begin
    test_reset;
    test_prime_stream;
    test_underflow;
    test_overflow;
    test_back_to_back;
    test_halt_flush;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/pwl_batch_buffer.md
Name: pwl_batch_buffer

Overview:
- Elastic batch FIFO directly downstream of pwl_generator, ahead of the DAC0 output stream.
- Absorbs valid_batch_out/batch_out bursts from the generator and drives dac0_rdy back as flow control.
- Primes to a fill level before streaming, and presents batches to the DAC on a valid/ready handshake.
- Counts underflows and flags dropped batches.

Parameters:
- SAMPLE_WIDTH, 16, bits per sample
- BATCH_WIDTH, 256, bits per batch; BATCH_SAMPLES = BATCH_WIDTH/SAMPLE_WIDTH
- FIFO_DEPTH, 8, batch entries; power of two, at least 4
- RDY_MARGIN, 2, free entries reserved to cover generator latency after dac0_rdy falls
- PRIME_LEVEL, 4, entries required before streaming starts; at most FIFO_DEPTH
- UFLOW_CNT_WIDTH, 16, underflow counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- batch_in  in  [BATCH_SAMPLES-1:0][SAMPLE_WIDTH-1:0]  batch from generator
- valid_batch_in  in  1  batch_in qualifier, one batch per cycle
- dac0_rdy  out  1  high when count < FIFO_DEPTH-RDY_MARGIN
- run  in  1  pulse; arms streaming
- halt  in  1  pulse; stop and flush
- batch_out  out  [BATCH_SAMPLES-1:0][SAMPLE_WIDTH-1:0]  batch to DAC
- valid_out  out  1  batch_out qualifier
- ready_in  in  1  DAC accepts batch_out
- active  out  1  high in PRIME or STREAM
- overflow  out  1  sticky; a batch was dropped
- underflow_cnt  out  UFLOW_CNT_WIDTH  saturating underflow count

Behaviour:
- Reset values: count=0, pointers=0, state IDLE, valid_out=0, batch_out=0, dac0_rdy=1, active=0, overflow=0, underflow_cnt=0.
- FIFO storage:
  - Write when valid_batch_in and (count<FIFO_DEPTH or a read occurs the same cycle).
  - Otherwise the batch is dropped and overflow<=1.
- Read fires when valid_out && ready_in.
- Output register is first-word-fall-through. A batch written in cycle N is on batch_out no earlier than cycle N+1, and only while state is STREAM.
- count tracks writes and reads:
  - Simultaneous read and write leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- dac0_rdy is combinational from registered count only; no path from ready_in.
- State machine:
  - IDLE: active=0, valid_out=0. Writes are accepted. On run, go to PRIME and clear overflow.
  - PRIME: active=1, valid_out=0. Go to STREAM when count>=PRIME_LEVEL; the comparison uses registered count.
  - STREAM: valid_out=(count>0). If ready_in && count==0, increment underflow_cnt, saturating at all-ones.
  - FLUSH: lasts one cycle. Pointers and count go to 0, valid_out=0, writes that cycle are ignored, then go to IDLE.
- halt in PRIME or STREAM goes to FLUSH next cycle and overrides run the same cycle. halt in IDLE also flushes.
- run in PRIME or STREAM is ignored. run while already count>=PRIME_LEVEL passes through PRIME in one cycle.
- underflow_cnt clears only on rst.
- rst mid-stream returns all state to reset values; FIFO contents are discarded.

Optional Feature:
- Macro: PWL_BUF_IDLE_HOLD_EN.
- Defined: in STREAM with count==0, valid_out=1 and batch_out is BATCH_SAMPLES copies of sample index BATCH_SAMPLES-1 of the last batch read (0 if none since reset/flush). Underflow is still counted, and the hold batch consumes no FIFO entry.
- Undefined: valid_out=0 whenever the FIFO is empty.

Decomposition:
- Package pwl_buf_pkg holds:
  - state enum {IDLE, PRIME, STREAM, FLUSH}
  - batch_t packed typedef built from SAMPLE_WIDTH and BATCH_SAMPLES
  - BATCH_SAMPLES localparam helper
- One sub-module, batch_fifo_sync: a synchronous FIFO of batch_t with count, a full flag, a flush input and FWFT output.
- The top level holds the state machine, flow control and counters.

Test Plan (FIFO_DEPTH=8, RDY_MARGIN=2, PRIME_LEVEL=4):
- Reset, no stimulus -> valid_out=0, dac0_rdy=1, overflow=0, underflow_cnt=0, active=0.
- 6 writes (batch k = all samples k, k=1..6) in IDLE, then run, ready_in=1:
  - dac0_rdy falls the cycle after the 6th write.
  - PRIME lasts 1 cycle, then valid_out=1.
  - Batches 1..6 come out in order on consecutive cycles.
  - dac0_rdy rises once count<6.
- 9 writes, ready_in=0 -> 9th dropped, count=8, overflow=1; next run clears overflow.
- STREAM, FIFO drains, ready_in=1 held 3 cycles while empty:
  - underflow_cnt=3.
  - valid_out=0, or held last sample with valid_out=1 when PWL_BUF_IDLE_HOLD_EN is defined.
- halt in STREAM with 5 entries -> FLUSH next cycle, then IDLE, count=0, valid_out=0, active=0; a write during the FLUSH cycle is not stored.
- FIFO full (8), valid_batch_in and read in the same cycle -> write accepted, count stays 8, overflow stays 0, order preserved.
